ram_arbiter: RTL and testbench

- Arbitrates the single-port data/program RAM of the K-and-S core between two requesters:
  - port 0: the processor datapath (fetch, load, store);
  - port 1: the debug/program-loader port.
- Uses round-robin priority and a committed request/grant/read-valid handshake.
- Sits between the control unit/datapath address mux and the RAM, and owns all RAM control signals.

---
 rtl/ram_arbiter.sv | 143 ++++++++++++++
 tb/tb_ram_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for the single-port K-and-S RAM: cpu (port 0) vs debug/loader (port 1).
// Optional RAM_ARB_LOCK_EN adds a per-port lock input that keeps ownership across accesses.
module ram_arbiter #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req,
    input  logic [1:0]             we,
    input  logic [1:0][ADDR_W-1:0] addr,
    input  logic [1:0][DATA_W-1:0] wdata,
`ifdef RAM_ARB_LOCK_EN
    input  logic [1:0]             lock,
`endif
    output logic [1:0]             gnt,
    output logic [1:0]             rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic                   ram_we,
    output logic [DATA_W-1:0]      ram_wdata,
    input  logic [DATA_W-1:0]      ram_rdata,
    output logic                   busy
);

    localparam int unsigned CntW = 2;

    typedef enum logic [1:0] {StIdle, StAccess, StRdWait} state_e;

    state_e              state_q;
    logic                owner_q;
    logic                ptr_q;
    logic [CntW-1:0]     cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                eff_ptr;
    logic                winner;
    logic [1:0]          cand;
    logic                in_access;
    logic                rd_done;

`ifdef RAM_ARB_LOCK_EN
    logic                locked_q;
    logic                keep_lock;
`endif

    // Arbitration: pointer port wins if it requests, otherwise the other port.
    always_comb begin
        cand    = req;
        eff_ptr = ptr_q;
`ifdef RAM_ARB_LOCK_EN
        keep_lock = locked_q && req[owner_q] && lock[owner_q];
        if (keep_lock) begin
            cand = owner_q ? 2'b10 : 2'b01;
        end else if (locked_q) begin
            eff_ptr = ~owner_q;
        end
`endif
        winner = cand[eff_ptr] ? eff_ptr : ~eff_ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            ptr_q    <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
`ifdef RAM_ARB_LOCK_EN
            locked_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
`ifdef RAM_ARB_LOCK_EN
                    if (locked_q && !keep_lock) begin
                        locked_q <= 1'b0;
                        ptr_q    <= ~owner_q;
                    end
`endif
                    if (|cand) begin
                        owner_q <= winner;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    addr_q  <= addr[owner_q];
                    wdata_q <= wdata[owner_q];
`ifdef RAM_ARB_LOCK_EN
                    if (lock[owner_q]) begin
                        locked_q <= 1'b1;
                    end else begin
                        locked_q <= 1'b0;
                        ptr_q    <= ~owner_q;
                    end
`else
                    ptr_q <= ~owner_q;
`endif
                    if (we[owner_q]) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q   <= CntW'(RD_LATENCY - 1);
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (cnt_q == '0) begin
                        rdata_q <= ram_rdata;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_access = (state_q == StAccess);
    assign rd_done   = (state_q == StRdWait) && (cnt_q == '0);
    assign busy      = (state_q != StIdle);
    assign ram_we    = in_access && we[owner_q];

    // Address/data follow the owner live in ACCESS, then hold the latched copy.
    assign ram_addr  = in_access ? addr[owner_q]  : addr_q;
    assign ram_wdata = in_access ? wdata[owner_q] : wdata_q;

    // Present RAM data straight through in the rvalid cycle; hold it afterwards.
    assign rdata     = rd_done ? ram_rdata : rdata_q;

    always_comb begin
        gnt    = 2'b00;
        rvalid = 2'b00;
        if (in_access) gnt[owner_q] = 1'b1;
        if (rd_done)   rvalid[owner_q] = 1'b1;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected grant/read events, a monitor checks them.
// Lock scenario is compiled only when RAM_ARB_LOCK_EN is defined.
module tb_ram_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 16;
    localparam int unsigned L  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          req;
    logic [1:0]          we;
    logic [1:0][AW-1:0]  addr;
    logic [1:0][DW-1:0]  wdata;
`ifdef RAM_ARB_LOCK_EN
    logic [1:0]          lock;
`endif
    logic [1:0]          gnt;
    logic [1:0]          rvalid;
    logic [DW-1:0]       rdata;
    logic [AW-1:0]       ram_addr;
    logic                ram_we;
    logic [DW-1:0]       ram_wdata;
    logic [DW-1:0]       ram_rdata;
    logic                busy;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
`ifdef RAM_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-content RAM with L-cycle read pipeline.
    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        case (a)
            5'h1F:   return 16'h1234;
            5'h07:   return 16'hBEEF;
            5'h03:   return 16'hA5A5;
            default: return {11'h000, a};
        endcase
    endfunction

    logic [DW-1:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= rom(ram_addr);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata = pipe[L-1];

    typedef struct {
        bit          is_rv;
        int          port;
        int          cyc;
        bit          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input int act, input int req_v);
        n_checks++;
        if (act == req_v) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req_v, cyc);
    endtask

    task automatic push_gnt(input int port, input int c, input bit wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.is_rv = 1'b0; e.port = port; e.cyc = c; e.wr = wr; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_rv(input int port, input int c, input logic [DW-1:0] d);
        exp_t e;
        e.is_rv = 1'b1; e.port = port; e.cyc = c; e.wr = 1'b0; e.a = '0; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input bit is_rv, input logic [1:0] bits);
        exp_t e;
        int   port;
        port = bits[1] ? 1 : 0;
        chk(is_rv ? "rvalid_onehot" : "gnt_onehot", int'(bits == 2'b01 || bits == 2'b10), 1);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_%s: got bits %b, required none (cycle %0d)",
                     is_rv ? "rvalid" : "gnt", bits, cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", int'(is_rv), int'(e.is_rv));
        chk("event_port", port, e.port);
        chk("event_cycle", cyc, e.cyc);
        if (!is_rv) begin
            chk("ram_addr", int'(ram_addr), int'(e.a));
            chk("ram_we", int'(ram_we), int'(e.wr));
            if (e.wr) chk("ram_wdata", int'(ram_wdata), int'(e.d));
        end else begin
            chk("rdata", int'(rdata), int'(e.d));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt != 2'b00)    check_event(1'b0, gnt);
            if (rvalid != 2'b00) check_event(1'b1, rvalid);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        repeat (6) step();
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, int'(gnt), 0);
        chk({tag, "_rvalid"}, int'(rvalid), 0);
        chk({tag, "_rdata"}, int'(rdata), 0);
        chk({tag, "_ram_we"}, int'(ram_we), 0);
        chk({tag, "_ram_addr"}, int'(ram_addr), 0);
        chk({tag, "_ram_wdata"}, int'(ram_wdata), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    int c;

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        we    = 2'b00;
        addr  = '0;
        wdata = '0;
`ifdef RAM_ARB_LOCK_EN
        lock  = 2'b00;
`endif
        #1;
        check_all_zero("reset");
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Single write from port 0.
        c = cyc;
        req = 2'b01; we = 2'b01; addr[0] = 5'h03; wdata[0] = 16'hA5A5;
        push_gnt(0, c + 1, 1'b1, 5'h03, 16'hA5A5);
        step();
        chk("write_busy_access", int'(busy), 1);
        req = 2'b00;
        step();
        chk("write_busy_after", int'(busy), 0);
        drain("write_drain");

        // Single read from port 1.
        c = cyc;
        req = 2'b10; we = 2'b00; addr[1] = 5'h1F;
        push_gnt(1, c + 1, 1'b0, 5'h1F, 16'h0000);
        push_rv(1, c + 1 + L, 16'h1234);
        step();
        req = 2'b00;
        drain("read_drain");
        chk("read_rdata_held", int'(rdata), 16'h1234);

        // Contention from reset: strict alternation, one grant per 2 cycles.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        c = cyc;
        req = 2'b11; we = 2'b11;
        addr[0] = 5'h0A; wdata[0] = 16'h1111;
        addr[1] = 5'h15; wdata[1] = 16'h2222;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push_gnt(0, c + 1 + 2 * k, 1'b1, 5'h0A, 16'h1111);
            else            push_gnt(1, c + 1 + 2 * k, 1'b1, 5'h15, 16'h2222);
        end
        repeat (11) step();
        req = 2'b00;
        drain("contention_drain");

        // Port 1 raises req during port 0's read wait.
        c = cyc;
        req = 2'b01; we = 2'b00; addr[0] = 5'h07;
        push_gnt(0, c + 1, 1'b0, 5'h07, 16'h0000);
        push_rv(0, c + 1 + L, 16'hBEEF);
        push_gnt(1, c + 3 + L, 1'b1, 5'h08, 16'h5A5A);
        step();
        req[0] = 1'b0;
        step();
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 5'h08; wdata[1] = 16'h5A5A;
        repeat (3) step();
        req = 2'b00;
        drain("late_drain");

        // Reset during read wait: no rvalid, pointer back to port 0.
        c = cyc;
        req = 2'b01; we = 2'b00; addr[0] = 5'h07;
        push_gnt(0, c + 1, 1'b0, 5'h07, 16'h0000);
        step();
        req = 2'b00;
        step();
        chk("midread_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) step();
        rst_n = 1'b1;
        drain("midreset_drain");
        c = cyc;
        req = 2'b11; we = 2'b11;
        addr[0] = 5'h01; wdata[0] = 16'h0A0A;
        addr[1] = 5'h02; wdata[1] = 16'h0B0B;
        push_gnt(0, c + 1, 1'b1, 5'h01, 16'h0A0A);
        push_gnt(1, c + 3, 1'b1, 5'h02, 16'h0B0B);
        repeat (3) step();
        req = 2'b00;
        drain("postreset_drain");

`ifdef RAM_ARB_LOCK_EN
        // Port 0 locks across a read and a write; port 1 waits until lock drops.
        c = cyc;
        req = 2'b11; we = 2'b10; lock = 2'b01;
        addr[0] = 5'h03;
        addr[1] = 5'h10; wdata[1] = 16'h3333;
        push_gnt(0, c + 1, 1'b0, 5'h03, 16'h0000);
        push_rv(0, c + 1 + L, 16'hA5A5);
        push_gnt(0, c + 3 + L, 1'b1, 5'h04, 16'h4444);
        push_gnt(1, c + 5 + L, 1'b1, 5'h10, 16'h3333);
        push_gnt(0, c + 7 + L, 1'b1, 5'h04, 16'h4444);
        push_gnt(1, c + 9 + L, 1'b1, 5'h10, 16'h3333);
        repeat (2) step();
        we[0] = 1'b1; addr[0] = 5'h04; wdata[0] = 16'h4444;
        repeat (3 + L - 2) step();
        req[0] = 1'b0; lock = 2'b00;
        repeat (2) step();
        req[0] = 1'b1;
        repeat (4) step();
        req = 2'b00;
        drain("lock_drain");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
